// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BIOS memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles in which fetch loses to data; flags when fetch must be forced to win.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic i_gnt,
  input  logic state,
  output logic force_next
);

  localparam logic [STARVE_W-1:0] CntLast = STARVE_W'(STARVE_MAX - 1);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    force_next = 1'b0;
    cnt_d      = cnt_q;
    if (state_e'(state) == ST_ARB) begin
      if (i_gnt || !i_req) begin
        cnt_d = '0;
      end else if (d_req) begin
        if (cnt_q == CntLast) begin
          force_next = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bios_mem_arbiter.sv
// Arbitrates fetch and data ports onto one synchronous-read BIOS memory, data first with a
// starvation guard. Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module bios_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       stat_conflicts,
  output logic [31:0]       stat_forced
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   rd_pending_q, rd_pending_d;
  logic   force_next;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .d_req     (d_req),
    .i_gnt     (i_gnt),
    .state     (state_q),
    .force_next(force_next)
  );

  always_comb begin
    d_gnt   = 1'b0;
    i_gnt   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ST_ARB: begin
        d_gnt = d_req;
        i_gnt = i_req & ~d_req;
        if (force_next) state_d = ST_FORCE;
      end
      ST_FORCE: begin
        i_gnt = i_req;
        d_gnt = d_req & ~i_req;
        if (i_gnt || !i_req) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    mem_we   = 4'b0000;
    mem_addr = '0;
    mem_din  = '0;
    if (d_gnt) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_din  = d_wdata;
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
  end

  assign mem_en = d_gnt | i_gnt;

  // Owner only changes on a grant so the returning read always routes to its issuer.
  always_comb begin
    owner_d      = owner_q;
    rd_pending_d = mem_en & (mem_we == 4'b0000);
    if (d_gnt) begin
      owner_d = OWN_D;
    end else if (i_gnt) begin
      owner_d = OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      owner_q      <= OWN_D;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign d_rvalid = rd_pending_q & (owner_q == OWN_D);
  assign i_rvalid = rd_pending_q & (owner_q == OWN_I);
  assign d_rdata  = mem_dout;
  assign i_rdata  = mem_dout;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] conflicts_q, forced_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflicts_q <= '0;
      forced_q    <= '0;
    end else begin
      if (d_req && i_req && (conflicts_q != 32'hFFFF_FFFF)) conflicts_q <= conflicts_q + 1'b1;
      if ((state_q == ST_FORCE) && i_gnt && (forced_q != 32'hFFFF_FFFF)) begin
        forced_q <= forced_q + 1'b1;
      end
    end
  end

  assign stat_conflicts = conflicts_q;
  assign stat_forced    = forced_q;
`else
  assign stat_conflicts = 32'd0;
  assign stat_forced    = 32'd0;
`endif

endmodule

// File: tb/tb_bios_mem_arbiter.sv
// Directed bench for bios_mem_arbiter with a byte-writable synchronous-read memory model.
module tb_bios_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_req, i_req;
  logic [3:0]    d_we;
  logic [AW-1:0] d_addr, i_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid, i_gnt, i_rvalid;
  logic [31:0]   d_rdata, i_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic [31:0]   stat_conflicts, stat_forced;

  logic [31:0]   mem_model [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bios_mem_arbiter #(
    .ADDR_W    (AW),
    .STARVE_MAX(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_gnt         (d_gnt),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_gnt         (i_gnt),
    .i_rvalid      (i_rvalid),
    .i_rdata       (i_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .stat_conflicts(stat_conflicts),
    .stat_forced   (stat_forced)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we[0]) mem_model[mem_addr][7:0]   <= mem_din[7:0];
      if (mem_we[1]) mem_model[mem_addr][15:8]  <= mem_din[15:8];
      if (mem_we[2]) mem_model[mem_addr][23:16] <= mem_din[23:16];
      if (mem_we[3]) mem_model[mem_addr][31:24] <= mem_din[31:24];
      if (mem_we == 4'b0000) mem_dout <= mem_model[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req   = 1'b0;
    d_we    = 4'b0000;
    d_addr  = '0;
    d_wdata = '0;
    i_req   = 1'b0;
    i_addr  = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] data, input logic [3:0] we);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = data;
    #1;
    chk("wr_gnt", 32'(d_gnt), 32'd1);
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_gnt", {30'd0, d_gnt, i_gnt}, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_stat_conf", stat_conflicts, 32'd0);
    chk("rst_stat_forced", stat_forced, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_ARB));

    // Preload memory through the data port.
    wr(12'h010, 32'h0050_0093, 4'hF);
    wr(12'h020, 32'h1111_2222, 4'hF);
    wr(12'h011, 32'h3333_4444, 4'hF);
    wr(12'h030, 32'hFFFF_FFFF, 4'hF);
    for (int k = 0; k < 8; k++) wr(AW'(12'h040 + k), 32'hC0DE_0000 + 32'(k), 4'hF);

    // Lone fetch.
    i_req  = 1'b1;
    i_addr = 12'h010;
    #1;
    chk("t1_i_gnt", 32'(i_gnt), 32'd1);
    chk("t1_d_gnt", 32'(d_gnt), 32'd0);
    chk("t1_mem_addr", 32'(mem_addr), 32'h010);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    tick();
    idle();
    #1;
    chk("t1_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h0050_0093);
    chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);

    // Simultaneous requests: data wins, fetch follows.
    d_req  = 1'b1;
    d_addr = 12'h020;
    i_req  = 1'b1;
    i_addr = 12'h011;
    #1;
    chk("t2_d_gnt", 32'(d_gnt), 32'd1);
    chk("t2_i_gnt", 32'(i_gnt), 32'd0);
    chk("t2_mem_addr", 32'(mem_addr), 32'h020);
    tick();
    d_req = 1'b0;
    #1;
    chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t2_d_rdata", d_rdata, 32'h1111_2222);
    chk("t2_i_gnt_after", 32'(i_gnt), 32'd1);
    tick();
    idle();
    #1;
    chk("t2_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("t2_i_rdata", i_rdata, 32'h3333_4444);

    // Starvation guard: clean stats first.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    d_req  = 1'b1;
    d_addr = 12'h020;
    i_req  = 1'b1;
    i_addr = 12'h010;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("t3_i_gnt_c%0d", k), 32'(i_gnt), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("t3_d_gnt_c%0d", k), 32'(d_gnt), (k == 5) ? 32'd0 : 32'd1);
      if (k == 5) chk("t3_state_force", 32'(dut.state_q), 32'(ST_FORCE));
      if (k == 6) begin
        chk("t3_state_arb", 32'(dut.state_q), 32'(ST_ARB));
        chk("t3_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("t3_i_rdata", i_rdata, 32'h0050_0093);
      end
      tick();
    end
    idle();
    #1;
`ifdef MEM_ARB_STATS_EN
    chk("t3_stat_conf", stat_conflicts, 32'd6);
    chk("t3_stat_forced", stat_forced, 32'd1);
`else
    chk("t3_stat_conf", stat_conflicts, 32'd0);
    chk("t3_stat_forced", stat_forced, 32'd0);
`endif

    // Partial write then read-back.
    d_req   = 1'b1;
    d_we    = 4'b0011;
    d_addr  = 12'h030;
    d_wdata = 32'h0000_ABCD;
    #1;
    chk("t4_mem_we", 32'(mem_we), 32'h3);
    chk("t4_mem_din", mem_din, 32'h0000_ABCD);
    chk("t4_mem_addr", 32'(mem_addr), 32'h030);
    tick();
    idle();
    #1;
    chk("t4_no_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd0);
    d_req  = 1'b1;
    d_addr = 12'h030;
    tick();
    idle();
    #1;
    chk("t4_rb_rvalid", 32'(d_rvalid), 32'd1);
    chk("t4_rb_rdata", d_rdata, 32'hFFFF_ABCD);

    // Alternating data/fetch reads, one per cycle.
    for (int j = 0; j <= 8; j++) begin
      idle();
      if (j < 8) begin
        if (j % 2 == 0) begin
          d_req  = 1'b1;
          d_addr = AW'(12'h040 + j);
        end else begin
          i_req  = 1'b1;
          i_addr = AW'(12'h040 + j);
        end
      end
      #1;
      if (j < 8) chk($sformatf("t5_mem_en_%0d", j), 32'(mem_en), 32'd1);
      if (j > 0) begin
        chk($sformatf("t5_rv_%0d", j), {30'd0, d_rvalid, i_rvalid},
            ((j - 1) % 2 == 0) ? 32'd2 : 32'd1);
        chk($sformatf("t5_data_%0d", j), ((j - 1) % 2 == 0) ? d_rdata : i_rdata,
            32'hC0DE_0000 + 32'(j - 1));
      end
      tick();
    end

    // Reset right after a granted data read, with starve count built up.
    d_req  = 1'b1;
    d_addr = 12'h020;
    i_req  = 1'b1;
    i_addr = 12'h010;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_pre_d_rvalid", 32'(d_rvalid), 32'd1);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("t6_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("t6_state", 32'(dut.state_q), 32'(ST_ARB));
    chk("t6_starve_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
    rst    = 1'b1;
    d_req  = 1'b1;
    d_addr = 12'h020;
    #1;
    chk("t6b_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("t6b_d_rvalid", 32'(d_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
